serial_subtractor: RTL and testbench

Multi-cycle, bit-serial two's-complement subtractor computing `a - b - bin` one bit per clock, LSB first, through a single 1-bit full-subtractor cell and a registered borrow. It is the subtracting counterpart of the ripple-carry adder datapath. It trades latency for area and gives the ALU a start/done handshake, so it can share operand buses with other multi-cycle units.

---
 rtl/arith_pkg.sv | 10 +
 rtl/serial_subtractor_full_sub.sv | 13 +
 rtl/serial_subtractor.sv | 110 +++++++++++
 tb/tb_serial_subtractor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the multi-cycle datapath units.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } serial_state_t;

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// One-bit full subtractor cell: diff = a - b - bin, with borrow out.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first through a single full_sub cell, with start/done handshake.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH);

    serial_state_t    state;
    serial_state_t    state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic             a_msb;
    logic             b_msb;
    logic [CW-1:0]    cnt;
    logic             d_c;
    logic             br_c;
    logic             last_c;

    full_sub u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .diff (d_c),
        .bout (br_c)
    );

    assign last_c = (cnt == CW'(WIDTH - 1));

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_c) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and registered outputs; result outputs only change on entry to DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            cnt    <= '0;
        end else begin
            busy <= (state_nxt != IDLE);
            done <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= bin;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    res_sr <= {d_c, res_sr[WIDTH-1:1]};
                    br     <= br_c;
                    cnt    <= cnt + CW'(1);
                    if (last_c) begin
                        diff <= {d_c, res_sr[WIDTH-1:1]};
                        bout <= br_c;
                        ovf  <= (a_msb != b_msb) && (d_c != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH=4.
module tb_serial_subtractor;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] diff;
        logic       bout;
        logic       ovf;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launch one operation; optionally re-pulse start (a=9,b=9) at sample index 'second'.
    task automatic run_op(input logic [3:0] ia, input logic [3:0] ib, input logic ibin,
                          input int second,
                          output logic [3:0] od, output logic ob, output logic oo,
                          output int done_idx, output int done_cnt, output int busy_cnt);
        int idx;
        @(negedge clk);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 1; busy_cnt = 0; done_cnt = 0; done_idx = 0;
        while (busy && idx <= 20) begin
            busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_idx == 0) done_idx = idx;
            end
            if (idx == second) begin
                start = 1'b1; a = 4'h9; b = 4'h9; bin = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            idx++;
        end
        if (idx > 20) begin
            checks++;
            errors++;
            $display("FAIL op_timeout: busy still %0d after %0d cycles, required 0", busy, idx);
        end
        od = diff; ob = bout; oo = ovf;
    endtask

    initial begin
        vec_t       vecs[5];
        logic [3:0] od;
        logic       ob, oo;
        int         didx, dcnt, bcnt;
        int         done_t[$];
        int         hold_err;
        int         quiet_done;
        int         ra, rb, rbin, full;
        logic [3:0] ediff;
        logic       ebout, eovf;

        vecs[0] = '{a: 4'h7, b: 4'h3, bin: 1'b0, diff: 4'h4, bout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 4'h3, b: 4'h7, bin: 1'b0, diff: 4'hC, bout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 4'h0, b: 4'h0, bin: 1'b1, diff: 4'hF, bout: 1'b1, ovf: 1'b0};
        vecs[3] = '{a: 4'h8, b: 4'h1, bin: 1'b0, diff: 4'h7, bout: 1'b0, ovf: 1'b1};
        vecs[4] = '{a: 4'h7, b: 4'hF, bin: 1'b0, diff: 4'h8, bout: 1'b1, ovf: 1'b1};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_diff", int'(diff), 0);
        chk("reset_bout", int'(bout), 0);
        chk("reset_ovf",  int'(ovf),  0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, 0, od, ob, oo, didx, dcnt, bcnt);
            chk($sformatf("vec%0d_diff", i), int'(od), int'(vecs[i].diff));
            chk($sformatf("vec%0d_bout", i), int'(ob), int'(vecs[i].bout));
            chk($sformatf("vec%0d_ovf", i),  int'(oo), int'(vecs[i].ovf));
            chk($sformatf("vec%0d_done_cnt", i), dcnt, 1);
            chk($sformatf("vec%0d_done_at_busy_cycle", i), didx, WIDTH + 1);
            chk($sformatf("vec%0d_busy_cycles", i), bcnt, WIDTH + 1);
        end

        // Start pulsed again during SHIFT must be ignored
        run_op(4'h5, 4'h2, 1'b0, 2, od, ob, oo, didx, dcnt, bcnt);
        chk("ignore_diff", int'(od), 3);
        chk("ignore_done_cnt", dcnt, 1);
        chk("ignore_busy_cycles", bcnt, WIDTH + 1);
        repeat (3) @(posedge clk);
        #1;
        chk("ignore_no_relaunch", int'(busy), 0);

        // Start held high: done every WIDTH+2 cycles, result held between pulses
        @(negedge clk);
        a = 4'h6; b = 4'h1; bin = 1'b0; start = 1'b1;
        hold_err = 0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            if (done) done_t.push_back(c);
            if (done_t.size() > 0 && diff != 4'h5) hold_err++;
        end
        start = 1'b0;
        chk("held_done_count", done_t.size(), 4);
        if (done_t.size() >= 3) begin
            chk("held_interval1", done_t[1] - done_t[0], WIDTH + 2);
            chk("held_interval2", done_t[2] - done_t[1], WIDTH + 2);
        end
        chk("held_result_hold", hold_err, 0);
        for (int c = 0; c < 20 && busy; c++) begin
            @(posedge clk); #1;
        end
        chk("held_drain_idle", int'(busy), 0);

        // Reset in the cycle after edge T+2 of an F-1 operation
        @(negedge clk);
        a = 4'hF; b = 4'h1; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_diff", int'(diff), 0);
        chk("midrst_bout", int'(bout), 0);
        chk("midrst_ovf",  int'(ovf),  0);
        quiet_done = 0;
        for (int c = 0; c < 12; c++) begin
            if (done || busy) quiet_done++;
            @(posedge clk); #1;
        end
        chk("midrst_no_done", quiet_done, 0);
        run_op(4'hF, 4'h1, 1'b0, 0, od, ob, oo, didx, dcnt, bcnt);
        chk("post_rst_diff", int'(od), 14);
        chk("post_rst_bout", int'(ob), 0);
        chk("post_rst_done_cnt", dcnt, 1);

        // Randomized operations against an arithmetic model
        for (int n = 0; n < 200; n++) begin
            ra = int'($urandom_range(15, 0));
            rb = int'($urandom_range(15, 0));
            rbin = int'($urandom_range(1, 0));
            full = ra - rb - rbin;
            ediff = 4'(full);
            ebout = (ra < rb + rbin);
            eovf = (ra >= 8) != (rb >= 8) && (ediff[3] != (ra >= 8));
            run_op(4'(ra), 4'(rb), rbin[0], 0, od, ob, oo, didx, dcnt, bcnt);
            chk($sformatf("rand%0d_diff a=%0h b=%0h bin=%0d", n, ra, rb, rbin), int'(od), int'(ediff));
            chk($sformatf("rand%0d_bout", n), int'(ob), int'(ebout));
            chk($sformatf("rand%0d_ovf", n),  int'(oo), int'(eovf));
            chk($sformatf("rand%0d_done_cnt", n), dcnt, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
